// File: rtl/bmp180_temp_calc_if.sv
// Bundle of the start/result handshake and divider-side signals of bmp180_temp_calc.
//   slave  : view of the compensation block itself (consumes I_*, drives O_*).
//   master : view of whoever starts runs and hosts the divider (drives I_*, consumes O_*).
// Signals:
//   I_EN        start pulse           I_UT, I_AC5, I_AC6  unsigned raw/calibration words
//   I_MC, I_MD  signed calibration    O_DIV_EN            one-cycle divider start
//   O_DIV_NUM   divider numerator     O_DIV_DEN           divider denominator
//   I_DIV_RSL   divider quotient      I_DIV_FN            divider done
//   O_B5, O_T   results               O_BUSY, O_FN, O_ERR status
interface bmp180_temp_calc_if #(
    parameter int unsigned DATA_DIV = 32
);
    logic                       I_EN;
    logic        [15:0]         I_UT;
    logic        [15:0]         I_AC5;
    logic        [15:0]         I_AC6;
    logic        [15:0]         I_MC;
    logic        [15:0]         I_MD;
    logic                       O_DIV_EN;
    logic signed [DATA_DIV-1:0] O_DIV_NUM;
    logic signed [DATA_DIV-1:0] O_DIV_DEN;
    logic signed [DATA_DIV-1:0] I_DIV_RSL;
    logic                       I_DIV_FN;
    logic signed [DATA_DIV-1:0] O_B5;
    logic signed [15:0]         O_T;
    logic                       O_BUSY;
    logic                       O_FN;
    logic                       O_ERR;

    modport slave (
        input  I_EN, I_UT, I_AC5, I_AC6, I_MC, I_MD, I_DIV_RSL, I_DIV_FN,
        output O_DIV_EN, O_DIV_NUM, O_DIV_DEN, O_B5, O_T, O_BUSY, O_FN, O_ERR
    );

    modport master (
        output I_EN, I_UT, I_AC5, I_AC6, I_MC, I_MD, I_DIV_RSL, I_DIV_FN,
        input  O_DIV_EN, O_DIV_NUM, O_DIV_DEN, O_B5, O_T, O_BUSY, O_FN, O_ERR
    );
endinterface

// File: rtl/bmp180_temp_calc.sv
// BMP180 true-temperature compensation. Captures UT/AC5/AC6/MC/MD on a start pulse, computes
// X1, requests X2 = (MC << 11) / (X1 + MD) from an external signed divider, then forms
// B5 = X1 + X2 and T = (B5 + 8) >>> 4.
// Ports:
//   CLK     system clock
//   I_RST   synchronous active-high reset
//   bus_io  slave view of bmp180_temp_calc_if (start, inputs, divider handshake, results)
module bmp180_temp_calc #(
    parameter int unsigned DATA_DIV    = 32,
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              I_RST,
    bmp180_temp_calc_if.slave bus_io
);
    localparam int unsigned CntW = $clog2(DIV_TIMEOUT + 1);

    typedef logic signed [DATA_DIV-1:0] word_t;

    localparam word_t RoundBias = word_t'(8);

    typedef enum logic [2:0] {
        StIdle,
        StCalcX1,
        StChkDen,
        StDivReq,
        StDivWait,
        StCalcT,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic        [15:0] ut_q, ut_d, ac5_q, ac5_d, ac6_q, ac6_d, mc_q, mc_d, md_q, md_d;
    word_t              x1_q, x1_d, x2_q, x2_d;
    word_t              num_q, num_d, den_q, den_d, b5_q, b5_d;
    logic signed [15:0] t_q, t_d;
    logic               err_q, err_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic signed [16:0] diff;
    logic signed [33:0] prod;
    word_t              x1_calc, den_calc, num_calc, sum;
    logic [CntW-1:0]    cnt_inc;

    // Datapath shared by several states; operands come only from captured registers.
    always_comb begin
        diff     = $signed({1'b0, ut_q}) - $signed({1'b0, ac6_q});
        prod     = 34'(diff) * 34'($signed({1'b0, ac5_q}));
        x1_calc  = word_t'(prod >>> 15);
        den_calc = x1_q + word_t'($signed(md_q));
        num_calc = word_t'($signed(mc_q)) <<< 11;
        sum      = x1_q + x2_q;
        cnt_inc  = cnt_q + CntW'(1);
    end

    always_comb begin
        state_d = state_q;
        ut_d    = ut_q;
        ac5_d   = ac5_q;
        ac6_d   = ac6_q;
        mc_d    = mc_q;
        md_d    = md_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        num_d   = num_q;
        den_d   = den_q;
        b5_d    = b5_q;
        t_d     = t_q;
        err_d   = err_q;
        cnt_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.I_EN) begin
                    ut_d    = bus_io.I_UT;
                    ac5_d   = bus_io.I_AC5;
                    ac6_d   = bus_io.I_AC6;
                    mc_d    = bus_io.I_MC;
                    md_d    = bus_io.I_MD;
                    err_d   = 1'b0;
                    state_d = StCalcX1;
                end
            end
            StCalcX1: begin
                x1_d    = x1_calc;
                state_d = StChkDen;
            end
            StChkDen: begin
                // A zero denominator skips the divider entirely and reports an error.
                if (den_calc == '0) begin
                    x2_d    = '0;
                    err_d   = 1'b1;
                    state_d = StCalcT;
                end else begin
                    num_d   = num_calc;
                    den_d   = den_calc;
                    state_d = StDivReq;
                end
            end
            StDivReq: begin
                state_d = StDivWait;
            end
            StDivWait: begin
                // Divider completion wins over a timeout landing in the same cycle.
                if (bus_io.I_DIV_FN) begin
                    x2_d    = bus_io.I_DIV_RSL;
                    state_d = StCalcT;
                end else if (cnt_inc == CntW'(DIV_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StCalcT: begin
                b5_d    = sum;
                t_d     = 16'((sum + RoundBias) >>> 4);
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (I_RST) begin
            state_q <= StIdle;
            ut_q    <= '0;
            ac5_q   <= '0;
            ac6_q   <= '0;
            mc_q    <= '0;
            md_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            num_q   <= '0;
            den_q   <= '0;
            b5_q    <= '0;
            t_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ut_q    <= ut_d;
            ac5_q   <= ac5_d;
            ac6_q   <= ac6_d;
            mc_q    <= mc_d;
            md_q    <= md_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            num_q   <= num_d;
            den_q   <= den_d;
            b5_q    <= b5_d;
            t_q     <= t_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_io.O_DIV_EN  = (state_q == StDivReq);
    assign bus_io.O_DIV_NUM = num_q;
    assign bus_io.O_DIV_DEN = den_q;
    assign bus_io.O_B5      = b5_q;
    assign bus_io.O_T       = t_q;
    assign bus_io.O_BUSY    = (state_q != StIdle);
    assign bus_io.O_FN      = (state_q == StDone);
    assign bus_io.O_ERR     = err_q;
endmodule
